time_set_controller: RTL and testbench

//  Sequences the seconds/minutes/hours overflow_counter chain of the clock.
//  In RUN it passes the 1 Hz strobe and carries through the chain. In SET modes it turns

---
 rtl/time_set_controller_pkg.sv | 14 +
 rtl/time_set_controller_autorepeat_timer.sv | 54 +++++
 rtl/time_set_controller.sv | 90 +++++++++
 tb/tb_time_set_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/time_set_controller_pkg.sv
// Shared mode encoding for the clock setting FSM and the display mux.
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_HR  = 2'd2
  } mode_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/time_set_controller_autorepeat_timer.sv
// Press/auto-repeat pulse generator: one pulse on entry, then repeat after a hold delay.
module autorepeat_timer
  import time_set_controller_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned REPEAT_DIV = 2
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_fast_stb,
  output logic o_pulse
);

  localparam int unsigned HW = cnt_width(HOLD_TICKS + 1);
  localparam int unsigned RW = cnt_width(REPEAT_DIV);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DIV - 1);

  logic          active_q;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          pulse_q;

  // Dropping i_active clears everything, so a strobe in the release cycle never pulses.
  always_ff @(posedge i_sysclk) begin
    if (i_reset || !i_active) begin
      active_q <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      pulse_q  <= 1'b0;
    end else if (!active_q) begin
      active_q <= 1'b1;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      pulse_q  <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
      if (i_fast_stb) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
          pulse_q <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/time_set_controller.sv
// Run/set sequencing for the seconds/minutes/hours counter chain.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned REPEAT_DIV = 2
) (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_sec_stb,
  input  logic       i_fast_stb,
  input  logic       i_min_btn,
  input  logic       i_hr_btn,
  input  logic       i_sec_ovf,
  input  logic       i_min_ovf,
  output logic       o_sec_en,
  output logic       o_sec_clr,
  output logic       o_min_en,
  output logic       o_hr_en,
  output logic [1:0] o_mode
);

  mode_t state, next_state;
  logic  set_active;
  logic  set_pulse;

  always_ff @(posedge i_sysclk) begin
    if (i_reset) state <= MODE_RUN;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MODE_RUN: begin
        if (i_hr_btn)       next_state = MODE_SET_HR;
        else if (i_min_btn) next_state = MODE_SET_MIN;
      end
      MODE_SET_MIN,
      MODE_SET_HR: begin
        if (!i_min_btn && !i_hr_btn) next_state = MODE_RUN;
      end
      default: next_state = MODE_RUN;
    endcase
  end

  // Timer sees the upcoming state so the entry pulse lands in the first SET cycle.
  always_comb begin
    set_active = (next_state != MODE_RUN) && !i_reset;
  end

  autorepeat_timer #(
    .HOLD_TICKS(HOLD_TICKS),
    .REPEAT_DIV(REPEAT_DIV)
  ) u_autorepeat (
    .i_sysclk  (i_sysclk),
    .i_reset   (i_reset),
    .i_active  (set_active),
    .i_fast_stb(i_fast_stb),
    .o_pulse   (set_pulse)
  );

  always_comb begin
    o_sec_en  = 1'b0;
    o_sec_clr = 1'b0;
    o_min_en  = 1'b0;
    o_hr_en   = 1'b0;
    if (!i_reset) begin
      case (state)
        MODE_RUN: begin
          o_sec_en = i_sec_stb;
          o_min_en = i_sec_ovf;
          o_hr_en  = i_min_ovf;
        end
        MODE_SET_MIN: begin
          o_sec_clr = 1'b1;
          o_min_en  = set_pulse;
        end
        MODE_SET_HR: begin
          o_sec_clr = 1'b1;
          o_hr_en   = set_pulse;
        end
        default: ;
      endcase
    end
  end

  assign o_mode = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench: vector table, multi-cycle hold/release/reset sequences, random vs model.
module tb_time_set_controller;

  localparam int HOLD = 8;
  localparam int DIV  = 2;

  logic       clk = 1'b0;
  logic       rst, sstb, fast, minb, hrb, sov, mov;
  logic       sec_en, sec_clr, min_en, hr_en;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;
  int n_min = 0;
  int n_hr  = 0;
  logic       ob_min, ob_hr, ob_sec;
  logic [1:0] ob_mode;

  always #5 clk = ~clk;

  time_set_controller #(
    .HOLD_TICKS(HOLD),
    .REPEAT_DIV(DIV)
  ) dut (
    .i_sysclk  (clk),
    .i_reset   (rst),
    .i_sec_stb (sstb),
    .i_fast_stb(fast),
    .i_min_btn (minb),
    .i_hr_btn  (hrb),
    .i_sec_ovf (sov),
    .i_min_ovf (mov),
    .o_sec_en  (sec_en),
    .o_sec_clr (sec_clr),
    .o_min_en  (min_en),
    .o_hr_en   (hr_en),
    .o_mode    (mode)
  );

  // {rst sstb fast min hr sov mov}_{sec_en clr min_en hr_en}_{mode}
  typedef struct packed {
    logic rst, sstb, fast, minb, hrb, sov, mov;
    logic e_sec, e_clr, e_min, e_hr;
    logic [1:0] e_mode;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, s, f, m, h, so, mo);
    rst = r; sstb = s; fast = f; minb = m; hrb = h; sov = so; mov = mo;
  endtask

  // One clock cycle: drive, sample mid-cycle, tally increment pulses, advance.
  task automatic cyc(input logic r, s, f, m, h, so, mo);
    drive(r, s, f, m, h, so, mo);
    @(negedge clk);
    ob_min = min_en; ob_hr = hr_en; ob_sec = sec_en; ob_mode = mode;
    if (min_en) n_min++;
    if (hr_en)  n_hr++;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: mode, whether a set pulse is due this cycle, strobes held so far.
  int   m_mode, m_held;
  logic m_pulse;

  initial begin
    int minute;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Vector table
    tbl[0]  = 13'b1100011_0000_00;
    tbl[1]  = 13'b0100011_1011_00;
    tbl[2]  = 13'b0000000_0000_00;
    tbl[3]  = 13'b0101000_1000_00;
    tbl[4]  = 13'b0011000_0110_01;
    tbl[5]  = 13'b0101011_0100_01;
    tbl[6]  = 13'b0000000_0100_01;
    tbl[7]  = 13'b0100000_1000_00;
    tbl[8]  = 13'b0001100_0000_00;
    tbl[9]  = 13'b0001100_0101_10;
    tbl[10] = 13'b0000100_0100_10;
    tbl[11] = 13'b0011000_0100_10;
    tbl[12] = 13'b0000000_0100_10;
    tbl[13] = 13'b0000000_0000_00;
    tbl[14] = 13'b0000010_0010_00;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].sstb, tbl[i].fast, tbl[i].minb, tbl[i].hrb, tbl[i].sov, tbl[i].mov);
      @(negedge clk);
      chk($sformatf("vec%0d.sec_en", i),  {7'd0, sec_en},  {7'd0, tbl[i].e_sec});
      chk($sformatf("vec%0d.sec_clr", i), {7'd0, sec_clr}, {7'd0, tbl[i].e_clr});
      chk($sformatf("vec%0d.min_en", i),  {7'd0, min_en},  {7'd0, tbl[i].e_min});
      chk($sformatf("vec%0d.hr_en", i),   {7'd0, hr_en},   {7'd0, tbl[i].e_hr});
      chk($sformatf("vec%0d.mode", i),    {6'd0, mode},    {6'd0, tbl[i].e_mode});
      @(posedge clk); #1;
    end

    // Long hold: 20 fast ticks -> entry + 6 repeats; minutes 58 -> 5
    n_min = 0; n_hr = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 20; t++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    minute = (58 + n_min) % 60;
    chk("hold20.pulses", 8'(n_min), 8'd7);
    chk("hold20.hr_pulses", 8'(n_hr), 8'd0);
    chk("hold20.minute", 8'(minute), 8'd5);

    // Reset during auto-repeat, on the strobe that would have pulsed
    n_min = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 9; t++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    n_min = 0;
    cyc(1, 1, 1, 1, 0, 0, 0);
    chk("rst.sec_en_in_reset", {7'd0, ob_sec}, 8'd0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("rst.mode_after", {6'd0, ob_mode}, 8'd0);
    chk("rst.no_pulse", 8'(n_min), 8'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst.sec_resume", {7'd0, ob_sec}, 8'd1);

    // Strobe coincident with release is ignored; next press restarts hold count
    n_min = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 9; t++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("release.after_min_en", {7'd0, ob_min}, 8'd0);
    chk("release.pulses", 8'(n_min), 8'd1);
    n_min = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 9; t++) begin
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("repress.pulses", 8'(n_min), 8'd1);

    // Random stimulus against the reference model
    m_mode = 0; m_held = 0; m_pulse = 1'b0;
    begin
      logic rm, rh;
      rm = 1'b0; rh = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        logic r, s, f, so, mo;
        logic e_sec, e_clr, e_min, e_hr;
        r  = (i == 0) || ($urandom_range(0, 79) == 0);
        s  = ($urandom_range(0, 7) == 0);
        f  = ($urandom_range(0, 2) == 0);
        so = ($urandom_range(0, 5) == 0);
        mo = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 24) == 0) rm = ~rm;
        if ($urandom_range(0, 39) == 0) rh = ~rh;
        drive(r, s, f, rm, rh, so, mo);
        @(negedge clk);
        e_sec = 0; e_clr = 0; e_min = 0; e_hr = 0;
        if (!r) begin
          if (m_mode == 0) begin
            e_sec = s; e_min = so; e_hr = mo;
          end else begin
            e_clr = 1;
            e_min = (m_mode == 1) && m_pulse;
            e_hr  = (m_mode == 2) && m_pulse;
          end
        end
        chk("rnd.sec_en",  {7'd0, sec_en},  {7'd0, e_sec});
        chk("rnd.sec_clr", {7'd0, sec_clr}, {7'd0, e_clr});
        chk("rnd.min_en",  {7'd0, min_en},  {7'd0, e_min});
        chk("rnd.hr_en",   {7'd0, hr_en},   {7'd0, e_hr});
        chk("rnd.mode",    {6'd0, mode},    8'(m_mode));
        if (r) begin
          m_mode = 0; m_pulse = 0; m_held = 0;
        end else if (m_mode == 0) begin
          m_held = 0;
          if (rh)      begin m_mode = 2; m_pulse = 1; end
          else if (rm) begin m_mode = 1; m_pulse = 1; end
          else m_pulse = 0;
        end else if (!rm && !rh) begin
          m_mode = 0; m_pulse = 0; m_held = 0;
        end else if (f) begin
          m_held++;
          m_pulse = (m_held > HOLD) && (((m_held - HOLD) % DIV) == 0);
        end else begin
          m_pulse = 0;
        end
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
